ear_adc: RTL and testbench
==========================

# ear_adc

Tape-input receiver for the Lynx core and the input counterpart of the output sigma-delta DAC path. It closes a first-order sigma-delta ADC loop around an external comparator and RC network. The 1-bit stream is decimated to 8-bit PCM samples by an order-2 CIC filter. A DC-tracking hysteresis slicer then recovers the 1-bit `ear` signal that feeds the machine's cassette-read logic.

## Interface
- `R_LOG2`, 4: log2 of the decimation ratio R; legal range 4..7.
- `HYST`, 8: half-width of the slicer hysteresis band, in sample LSBs (0..127).
- `AVG_SHIFT`, 4: time constant of the DC tracker; the mean moves by (sample-mean)/2^AVG_SHIFT per sample.

Ports:
- `clock  in  1`: system clock; all logic is on its rising edge.
- `reset  in  1`: synchronous, active-high reset.
- `cmp  in  1`: external comparator output, asynchronous to `clock`.
- `fb  out  1`: feedback bit to the RC integrator pin.
- `sample  out  8`: decimated unsigned PCM sample; 0x80 is mid-scale.
- `strobe  out  1`: one-cycle pulse marking a new valid `sample`.
- `ear  out  1`: sliced tape bit.

## Operation
- `cmp` passes through a 2-flop synchroniser, giving `bit`. `fb` is registered `bit`; this is the modulator loop, and `bit` is the ADC bitstream.
- The CIC is order 2, with differential delay 1 and ratio R = 2^R_LOG2.
  - It has two integrators running every clock, a phase counter 0..R-1, and two combs running on the decimated clock.
  - Internal width is W = 2*R_LOG2+1. Integrators wrap modulo 2^W, which is the correct CIC arithmetic.
  - Comb output y lies in 0..R^2.
- Sample formation: s = y saturated to R^2-1, then shifted right by (2*R_LOG2-8).
  - Full-scale input gives 0xFF.
  - A 50 % bit density gives 0x80.
- Settling: `strobe` is suppressed for the first 2 decimation periods after reset, while the comb history fills. From the 3rd period on, `strobe` asserts once per R clocks.
- The DC tracker holds `mean` as 16 bits in 8.8 fixed point; its reset value is 0x8000.
  - On each strobe: mean <= mean + ((sample<<8) - mean) >>> AVG_SHIFT, computed signed with 17-bit intermediate.
- Slicer thresholds:
  - hi = min(mean[15:8]+HYST, 255); lo = max(mean[15:8]-HYST, 0).
  - On each strobe: `ear` <= 1 if sample > hi; `ear` <= 0 if sample < lo; otherwise `ear` holds.
  - The comparison uses the mean value from before this strobe's update.
- Reset mid-operation clears the synchroniser, `fb`, integrators, combs, phase counter, settle counter, `mean`, and the outputs, all in the same cycle.

## Timing
- Reset values: `fb`=0, `sample`=0x00, `strobe`=0, `ear`=0.
- `cmp` to `bit` takes 2 clocks; `bit` to `fb` takes 1 clock.
- `strobe` is high exactly 1 clock.
  - `sample` updates in the same cycle `strobe` rises and holds until the next strobe.
  - `ear` and `mean` update on the clock after `strobe`.
- First `strobe` after reset release: clock 3R (phase counter wraps at R-1; periods 1 and 2 are suppressed).
- Steady-state latency from a bit change to full effect in `sample` is 2R clocks (CIC group delay R, plus one period).
- `ear` never changes more than once per R clocks.

## Structure
- Shared package holds:
  - default R_LOG2 / HYST / AVG_SHIFT;
  - the mean reset constant 0x8000;
  - the width function W(R_LOG2).
- Natural sub-module: `cic2_decim`.
  - Inputs: `bit`. Outputs: saturated 8-bit sample and a strobe, including the settle suppression.
  - The top level contains the synchroniser, feedback register, DC tracker and slicer.

## Test plan
- `cmp` held 1 (default parameters) -> first strobe at clock 48, `sample`=0xFF on every strobe. `ear` rises after the first strobe (0xFF > 0x80+8) and stays 1 while `mean` climbs toward 0xFF.
- `cmp` held 0 -> `sample`=0x00 on every strobe, `ear`=0 throughout, `mean` decays toward 0.
- `cmp` toggling every clock (1010...) -> `sample`=0x80 on every strobe after settling, `ear` remains 0.
- `cmp` as a 75 %/25 % density square wave, alternating every 512 clocks -> `sample` alternates 0xC0/0x40 and `ear` toggles once per half-period, 2R or fewer clocks after each density change.
- Density giving `sample`=0x86 with `mean`=0x80 and HYST=8 -> `ear` holds its prior value (inside the band). With HYST=0, `ear`=1.
- `reset` asserted for 1 clock mid-stream with `cmp` held 1 -> next cycle all outputs are at reset values and `mean`=0x8000; the next strobe arrives 3R clocks after reset release.

Source files
------------

// File: rtl/ear_adc_pkg.sv
// Shared constants and types for the tape-input sigma-delta receiver.
package ear_adc_pkg;

  localparam int          R_LOG2_DEF     = 4;
  localparam int          HYST_DEF       = 8;
  localparam int          AVG_SHIFT_DEF  = 4;
  localparam logic [15:0] MEAN_RST       = 16'h8000;
  // Decimation periods discarded after reset while the comb history fills.
  localparam int          SETTLE_PERIODS = 2;

  // Decimated PCM sample with its one-cycle valid strobe.
  typedef struct packed {
    logic [7:0] data;
    logic       vld;
  } pcm_t;

  // CIC register width: order 2 growth on a 1-bit input, plus one bit so R^2 fits.
  function automatic int cic_width(input int r_log2);
    return 2 * r_log2 + 1;
  endfunction

endpackage

// File: rtl/cic2_decim.sv
// Order-2 CIC decimator (differential delay 1, ratio 2^R_LOG2) turning the
// 1-bit modulator stream into saturated 8-bit PCM with a settle-gated strobe.
module cic2_decim
  import ear_adc_pkg::*;
#(
  parameter int R_LOG2 = R_LOG2_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output pcm_t pcm
);

  localparam int W  = cic_width(R_LOG2);
  localparam int SH = 2 * R_LOG2 - 8;
  // R^2 - 1 == 2^(W-1) - 1: all ones below the MSB.
  localparam logic [W-1:0] Y_MAX = {1'b0, {(W-1){1'b1}}};

  logic [W-1:0]      int1, int2, int2_d, comb1_d;
  logic [W-1:0]      comb1, y, y_sat;
  logic [R_LOG2-1:0] phase;
  logic [1:0]        settle;
  logic [7:0]        s;

  // Comb chain and sample formation; y only reaches the MSB at exactly R^2.
  always_comb begin
    comb1 = int2 - int2_d;
    y     = comb1 - comb1_d;
    y_sat = y[W-1] ? Y_MAX : y;
    s     = 8'(y_sat >> SH);
  end

  // Integrators every clock, combs and strobe once per R clocks.
  always_ff @(posedge clock) begin
    if (reset) begin
      int1    <= '0;
      int2    <= '0;
      int2_d  <= '0;
      comb1_d <= '0;
      phase   <= '0;
      settle  <= '0;
      pcm     <= '0;
    end else begin
      int1    <= int1 + W'(din);
      int2    <= int2 + int1;
      phase   <= phase + 1'b1;
      pcm.vld <= 1'b0;
      if (&phase) begin
        int2_d  <= int2;
        comb1_d <= comb1;
        if (settle == 2'(SETTLE_PERIODS)) begin
          pcm.vld  <= 1'b1;
          pcm.data <= s;
        end else begin
          settle <= settle + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/ear_adc.sv
// Tape-input receiver: comparator synchroniser and sigma-delta feedback,
// CIC decimation to 8-bit PCM, DC tracker and hysteresis slicer for `ear`.
module ear_adc
  import ear_adc_pkg::*;
#(
  parameter int R_LOG2    = R_LOG2_DEF,
  parameter int HYST      = HYST_DEF,
  parameter int AVG_SHIFT = AVG_SHIFT_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmp,
  output logic       fb,
  output logic [7:0] sample,
  output logic       strobe,
  output logic       ear
);

  logic               sync1, adc_bit;
  pcm_t               pcm;
  logic [15:0]        mean;
  logic signed [16:0] diff;
  logic [7:0]         hi, lo;

  // Two-flop synchroniser for the asynchronous comparator.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1   <= 1'b0;
      adc_bit <= 1'b0;
    end else begin
      sync1   <= cmp;
      adc_bit <= sync1;
    end
  end

  // Modulator feedback: the bitstream drives the RC integrator pin.
  always_ff @(posedge clock) begin
    if (reset) fb <= 1'b0;
    else       fb <= adc_bit;
  end

  cic2_decim #(.R_LOG2(R_LOG2)) u_cic (
    .clock (clock),
    .reset (reset),
    .din   (adc_bit),
    .pcm   (pcm)
  );

  assign sample = pcm.data;
  assign strobe = pcm.vld;

  // Tracker error and clamped hysteresis band around the current mean.
  always_comb begin
    diff = $signed({1'b0, sample, 8'h00}) - $signed({1'b0, mean});
    hi   = (mean[15:8] > 8'(255 - HYST)) ? 8'hFF : mean[15:8] + 8'(HYST);
    lo   = (mean[15:8] < 8'(HYST))       ? 8'h00 : mean[15:8] - 8'(HYST);
  end

  // On each strobe: slice against the pre-update mean, then move the mean.
  always_ff @(posedge clock) begin
    if (reset) begin
      mean <= MEAN_RST;
      ear  <= 1'b0;
    end else if (strobe) begin
      mean <= 16'($signed({1'b0, mean}) + (diff >>> AVG_SHIFT));
      if (sample > hi)      ear <= 1'b1;
      else if (sample < lo) ear <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ear_adc.sv
// Directed bench for ear_adc: table of steady bit patterns plus hand-built
// sequences for feedback latency, hysteresis band, square wave and mid-run reset.
module tb_ear_adc;

  localparam int R = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cmp   = 1'b0;
  logic       fb, strobe, ear;
  logic [7:0] sample;
  logic       fb_h0, strobe_h0, ear_h0;
  logic [7:0] sample_h0;

  int total = 0;
  int bad   = 0;

  ear_adc dut (
    .clock (clock), .reset (reset), .cmp (cmp),
    .fb (fb), .sample (sample), .strobe (strobe), .ear (ear)
  );

  ear_adc #(.HYST(0)) dut_h0 (
    .clock (clock), .reset (reset), .cmp (cmp),
    .fb (fb_h0), .sample (sample_h0), .strobe (strobe_h0), .ear (ear_h0)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          mode;       // 0 zeros, 1 ones, 2 toggle, 3 75 %, 4 25 %
    logic [7:0]  exp_sample;
    logic        exp_ear;
    logic [15:0] exp_mean1;  // mean after the first strobe
  } vec_t;

  vec_t vt [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    cmp   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  function automatic logic cmp_for(input int mode, input int e);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return e[0];
      3:       return (e % 4) != 0;
      default: return (e % 4) == 0;
    endcase
  endfunction

  int   first, last, nstb, sp_err, ear_err, e_h, lat;
  logic exp_e, prev_ear;
  int   chg [4];
  int   lat_at [4];

  initial begin
    vt[0] = '{0, 8'h00, 1'b0, 16'h7800};
    vt[1] = '{1, 8'hFF, 1'b1, 16'h87F0};
    vt[2] = '{2, 8'h80, 1'b0, 16'h8000};
    vt[3] = '{3, 8'hC0, 1'b1, 16'h8400};
    vt[4] = '{4, 8'h40, 1'b0, 16'h7C00};

    // Reset state.
    apply_reset();
    check("rst_fb", fb, 0);
    check("rst_sample", sample, 0);
    check("rst_strobe", strobe, 0);
    check("rst_ear", ear, 0);
    check("rst_mean", dut.mean, 16'h8000);

    // Table: steady patterns from reset.
    for (int v = 0; v < 5; v++) begin
      apply_reset();
      first = 0; last = 0; nstb = 0; sp_err = 0; ear_err = 0;
      for (int e = 1; e <= 176; e++) begin
        cmp = cmp_for(vt[v].mode, e);
        tick();
        if (strobe) begin
          nstb++;
          if (first == 0) first = e;
          else if (e - last != R) sp_err++;
          last = e;
          check($sformatf("v%0d_sample@%0d", v, e), sample, vt[v].exp_sample);
        end
        if (first != 0 && e == first + 1)
          check($sformatf("v%0d_mean1", v), dut.mean, vt[v].exp_mean1);
        exp_e = (first != 0 && e > first) ? vt[v].exp_ear : 1'b0;
        if (ear !== exp_e) ear_err++;
      end
      check($sformatf("v%0d_first_strobe", v), first, 3 * R);
      check($sformatf("v%0d_strobe_count", v), nstb, 9);
      check($sformatf("v%0d_spacing_errs", v), sp_err, 0);
      check($sformatf("v%0d_ear_errs", v), ear_err, 0);
    end

    // cmp -> fb is 3 clocks (2 sync + 1 feedback register).
    apply_reset();
    cmp = 1'b1;
    tick();
    tick();
    check("fb_at_2", fb, 0);
    tick();
    check("fb_at_3", fb, 1);

    // First sample 0x86 with mean 0x80: inside HYST=8 band, above HYST=0 threshold.
    apply_reset();
    for (int e = 1; e <= 49; e++) begin
      cmp = (e == 23) || (e >= 25 && e <= 33);
      tick();
      if (e == 48) begin
        check("band_strobe", strobe, 1);
        check("band_sample", sample, 8'h86);
        check("band_sample_h0", sample_h0, 8'h86);
      end
    end
    check("band_ear_h8", ear, 0);
    check("band_ear_h0", ear_h0, 1);

    // 75 %/25 % square wave, 512 clocks per half.
    apply_reset();
    prev_ear = 1'b0;
    for (int h = 0; h < 4; h++) begin chg[h] = 0; lat_at[h] = 0; end
    for (int e = 1; e <= 2048; e++) begin
      e_h = (e - 1) / 512;
      cmp = (e_h % 2 == 0) ? ((e % 4) != 0) : ((e % 4) == 0);
      tick();
      if (ear !== prev_ear) begin
        chg[e_h]++;
        lat_at[e_h] = e - (512 * e_h + 1);
      end
      prev_ear = ear;
      if (e == 496)  check("sq_sample_hi", sample, 8'hC0);
      if (e == 1008) check("sq_sample_lo", sample, 8'h40);
    end
    for (int h = 0; h < 4; h++)
      check($sformatf("sq_changes_h%0d", h), chg[h], 1);
    for (int h = 1; h < 4; h++) begin
      lat = lat_at[h];
      if (lat > 2 * R + 3) $display("sq latency half %0d = %0d clocks", h, lat);
      check($sformatf("sq_latency_ok_h%0d", h), (lat <= 2 * R + 3), 1);
    end
    check("sq_final_ear", ear, 0);

    // Mid-stream reset with cmp held high.
    apply_reset();
    cmp = 1'b1;
    for (int e = 1; e <= 100; e++) tick();
    check("mid_ear_before", ear, 1);
    check("mid_sample_before", sample, 8'hFF);
    reset = 1'b1;
    tick();
    check("mid_fb", fb, 0);
    check("mid_sample", sample, 0);
    check("mid_strobe", strobe, 0);
    check("mid_ear", ear, 0);
    check("mid_mean", dut.mean, 16'h8000);
    reset = 1'b0;
    first = 0;
    for (int e = 1; e <= 200 && first == 0; e++) begin
      tick();
      if (strobe) first = e;
    end
    check("mid_first_strobe", first, 3 * R);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
